// File: rtl/panel_pkg.sv
// Shared definitions for the panel power sequencer.
//   state_t      : sequencer state encoding (OFF=0 ... DN_SIG=7, 3 bits)
//   RATE_*       : frame-rate request codes, shared with pattern selection
//   DEF_*        : default timing constants (ms) and clock rate
//   is_busy()    : state -> oBUSY decode
//   rate_to_sel(): rate code -> DCLK source select (1 = 7 MHz)
package panel_pkg;

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_PWR_UP  = 3'd1,
    ST_SIG_UP  = 3'd2,
    ST_ON      = 3'd3,
    ST_RATE_BL = 3'd4,
    ST_RATE_SW = 3'd5,
    ST_DN_BL   = 3'd6,
    ST_DN_SIG  = 3'd7
  } state_t;

  localparam logic [1:0] RATE_60HZ = 2'd0;
  localparam logic [1:0] RATE_50HZ = 2'd1;

  localparam int DEF_TICKS_PER_MS = 16000;
  localparam int DEF_T_VDD_MS     = 10;
  localparam int DEF_T_SIG_MS     = 200;
  localparam int DEF_T_BLOFF_MS   = 10;
  localparam int DEF_T_SIGOFF_MS  = 50;
  localparam int DEF_T_SWITCH_MS  = 20;

  // Width of the millisecond counter; every T parameter must be 1..255.
  localparam int MS_W = 8;

  function automatic logic is_busy(input state_t s);
    return !(s == ST_OFF || s == ST_ON);
  endfunction

  // Only the 50 Hz code selects the 7 MHz source; unknown codes fall back to 60 Hz.
  function automatic logic rate_to_sel(input logic [1:0] rate);
    return (rate == RATE_50HZ);
  endfunction

endpackage

// File: rtl/panel_ms_timer.sv
// Millisecond interval timer: a prescaler dividing iCLK_PLL16 down to 1 ms
// and an 8-bit ms counter.
//   iCLK_PLL16 in  sequencer clock
//   iRESET     in  asynchronous active-low reset
//   clear      in  restart the interval (asserted on the state-entry edge)
//   t_ms       in  interval length in ms, 1..255
//   done       out high during the last cycle of a t_ms interval
module panel_ms_timer
  import panel_pkg::*;
#(
  parameter int TICKS_PER_MS = DEF_TICKS_PER_MS
) (
  input  logic            iCLK_PLL16,
  input  logic            iRESET,
  input  logic            clear,
  input  logic [MS_W-1:0] t_ms,
  output logic            done
);

  localparam int              PRE_W    = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICKS_PER_MS - 1);

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [MS_W-1:0]  ms_q, ms_d;
  logic             pre_wrap;

  // NOTE: every variable assigned here gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    pre_wrap = (pre_q == PRE_LAST);
    pre_d    = pre_q + 1'b1;
    ms_d     = ms_q;
    if (clear) begin
      pre_d = '0;
      ms_d  = '0;
    end else if (pre_wrap) begin
      pre_d = '0;
      ms_d  = ms_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops
  // sample pre-edge values regardless of statement order.
  always_ff @(posedge iCLK_PLL16 or negedge iRESET) begin
    if (!iRESET) begin
      pre_q <= '0;
      ms_q  <= '0;
    end else begin
      pre_q <= pre_d;
      ms_q  <= ms_d;
    end
  end

  // done is independent of clear, so the FSM can use it to pick the next
  // state without forming a combinational loop.
  assign done = pre_wrap && (ms_q == t_ms - 1'b1);

endmodule

// File: rtl/panel_power_seq.sv
// Panel power-on/off and frame-rate-switch sequencer (iCLK_PLL16 domain).
//   iENABLE, iPLL_LOCKED, iFRAME_RATE : asynchronous requests, synchronised here
//   oVDD_EN  panel supply enable       oSIG_EN  RGB/sync/DCLK output gate
//   oBL_EN   backlight enable          oSTB     copy of oSIG_EN
//   oCLK_SEL DCLK source (0 = 8 MHz, 1 = 7 MHz), only changed while blanked
//   oBUSY    high in every state except OFF and ON
// All outputs are registered and update on the same edge as the state.
module panel_power_seq
  import panel_pkg::*;
#(
  parameter int TICKS_PER_MS = DEF_TICKS_PER_MS,
  parameter int T_VDD_MS     = DEF_T_VDD_MS,
  parameter int T_SIG_MS     = DEF_T_SIG_MS,
  parameter int T_BLOFF_MS   = DEF_T_BLOFF_MS,
  parameter int T_SIGOFF_MS  = DEF_T_SIGOFF_MS,
  parameter int T_SWITCH_MS  = DEF_T_SWITCH_MS
) (
  input  logic       iCLK_PLL16,
  input  logic       iRESET,
  input  logic       iENABLE,
  input  logic       iPLL_LOCKED,
  input  logic [1:0] iFRAME_RATE,
  output logic       oVDD_EN,
  output logic       oSIG_EN,
  output logic       oBL_EN,
  output logic       oSTB,
  output logic       oCLK_SEL,
  output logic       oBUSY
);

  logic       en_meta_q, en_meta_d, en_sync_q, en_sync_d;
  logic       lock_meta_q, lock_meta_d, lock_sync_q, lock_sync_d;
  logic [1:0] rate_meta_q, rate_meta_d, rate_sync_q, rate_sync_d;
  logic [1:0] rate_hist_q, rate_hist_d, rate_acc_q, rate_acc_d;
  state_t     state_q, state_d;
  logic       vdd_q, vdd_d, sig_q, sig_d, bl_q, bl_d;
  logic       clk_sel_q, clk_sel_d, busy_q, busy_d;

  logic            go, req_sel, tmr_clear, tmr_done;
  logic [MS_W-1:0] tmr_t;

  // Synchronisers, plus a two-sample stability filter on the rate code:
  // a new code is accepted only once two consecutive synchronised samples
  // agree, and it is visible to the FSM in the same cycle it is accepted.
  always_comb begin
    en_meta_d   = iENABLE;
    en_sync_d   = en_meta_q;
    lock_meta_d = iPLL_LOCKED;
    lock_sync_d = lock_meta_q;
    rate_meta_d = iFRAME_RATE;
    rate_sync_d = rate_meta_q;
    rate_hist_d = rate_sync_q;
    rate_acc_d  = (rate_sync_q == rate_hist_q) ? rate_sync_q : rate_acc_q;
  end

  assign go      = en_sync_q & lock_sync_q;
  assign req_sel = rate_to_sel(rate_acc_d);

  always_comb begin
    tmr_t = MS_W'(1);
    case (state_q)
      ST_PWR_UP:             tmr_t = MS_W'(T_VDD_MS);
      ST_SIG_UP:             tmr_t = MS_W'(T_SIG_MS);
      ST_RATE_BL, ST_DN_BL:  tmr_t = MS_W'(T_BLOFF_MS);
      ST_RATE_SW:            tmr_t = MS_W'(T_SWITCH_MS);
      ST_DN_SIG:             tmr_t = MS_W'(T_SIGOFF_MS);
      default:               tmr_t = MS_W'(1);
    endcase
  end

  // Restart the interval on every state change so each timed state lasts
  // exactly T ms from its entry edge.
  assign tmr_clear = (state_d != state_q);

  panel_ms_timer #(
    .TICKS_PER_MS (TICKS_PER_MS)
  ) u_timer (
    .iCLK_PLL16 (iCLK_PLL16),
    .iRESET     (iRESET),
    .clear      (tmr_clear),
    .t_ms       (tmr_t),
    .done       (tmr_done)
  );

  // Next state. Losing go wins over a pending rate change; the two
  // power-down states ignore go until they reach OFF.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_OFF:     if (go) state_d = ST_PWR_UP;
      ST_PWR_UP:  if (!go) state_d = ST_DN_SIG;
                  else if (tmr_done) state_d = ST_SIG_UP;
      ST_SIG_UP:  if (!go) state_d = ST_DN_BL;
                  else if (tmr_done) state_d = ST_ON;
      ST_ON:      if (!go) state_d = ST_DN_BL;
                  else if (req_sel != clk_sel_q) state_d = ST_RATE_BL;
      ST_RATE_BL: if (!go) state_d = ST_DN_BL;
                  else if (tmr_done) state_d = ST_RATE_SW;
      ST_RATE_SW: if (!go) state_d = ST_DN_SIG;
                  else if (tmr_done) state_d = ST_SIG_UP;
      ST_DN_BL:   if (tmr_done) state_d = ST_DN_SIG;
      ST_DN_SIG:  if (tmr_done) state_d = ST_OFF;
      default:    state_d = ST_OFF;
    endcase
  end

  // Outputs decoded from the next state and registered alongside it.
  always_comb begin
    vdd_d     = vdd_q;
    sig_d     = sig_q;
    bl_d      = bl_q;
    clk_sel_d = clk_sel_q;
    busy_d    = is_busy(state_d);
    unique case (state_d)
      ST_OFF:                 begin vdd_d = 1'b0; sig_d = 1'b0; bl_d = 1'b0; end
      ST_PWR_UP, ST_RATE_SW,
      ST_DN_SIG:              begin vdd_d = 1'b1; sig_d = 1'b0; bl_d = 1'b0; end
      ST_SIG_UP, ST_RATE_BL:  begin vdd_d = 1'b1; sig_d = 1'b1; bl_d = 1'b0; end
      ST_ON:                  begin vdd_d = 1'b1; sig_d = 1'b1; bl_d = 1'b1; end
      ST_DN_BL:               bl_d = 1'b0;
      default:                begin vdd_d = 1'b0; sig_d = 1'b0; bl_d = 1'b0; end
    endcase
    // The select moves only while the signal outputs are (or become) blanked:
    // continuously in OFF, and once on the edge entering RATE_SW.
    if (state_q == ST_OFF)
      clk_sel_d = req_sel;
    if (state_d == ST_RATE_SW && state_q != ST_RATE_SW)
      clk_sel_d = req_sel;
  end

  always_ff @(posedge iCLK_PLL16 or negedge iRESET) begin
    if (!iRESET) begin
      en_meta_q   <= 1'b0;
      en_sync_q   <= 1'b0;
      lock_meta_q <= 1'b0;
      lock_sync_q <= 1'b0;
      rate_meta_q <= RATE_60HZ;
      rate_sync_q <= RATE_60HZ;
      rate_hist_q <= RATE_60HZ;
      rate_acc_q  <= RATE_60HZ;
      state_q     <= ST_OFF;
      vdd_q       <= 1'b0;
      sig_q       <= 1'b0;
      bl_q        <= 1'b0;
      clk_sel_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      en_meta_q   <= en_meta_d;
      en_sync_q   <= en_sync_d;
      lock_meta_q <= lock_meta_d;
      lock_sync_q <= lock_sync_d;
      rate_meta_q <= rate_meta_d;
      rate_sync_q <= rate_sync_d;
      rate_hist_q <= rate_hist_d;
      rate_acc_q  <= rate_acc_d;
      state_q     <= state_d;
      vdd_q       <= vdd_d;
      sig_q       <= sig_d;
      bl_q        <= bl_d;
      clk_sel_q   <= clk_sel_d;
      busy_q      <= busy_d;
    end
  end

  assign oVDD_EN  = vdd_q;
  assign oSIG_EN  = sig_q;
  assign oSTB     = sig_q;
  assign oBL_EN   = bl_q;
  assign oCLK_SEL = clk_sel_q;
  assign oBUSY    = busy_q;

endmodule

// File: tb/tb_panel_power_seq.sv
// Self-checking bench for panel_power_seq with a reduced time base
// (4 cycles per ms). Each scenario pushes the expected per-edge output
// vector {VDD, SIG, BL, STB, CLK_SEL, BUSY} into a queue as it drives
// stimulus, then steps the clock and pops/compares one entry per edge.
module tb_panel_power_seq;

  localparam int E_OFF = 0, E_PWR = 1, E_SIG = 2, E_ON = 3,
                 E_RBL = 4, E_RSW = 5, E_DBL = 6, E_DSIG = 7;

  logic       iCLK_PLL16, iRESET, iENABLE, iPLL_LOCKED;
  logic [1:0] iFRAME_RATE;
  logic       oVDD_EN, oSIG_EN, oBL_EN, oSTB, oCLK_SEL, oBUSY;
  logic [5:0] obs;

  typedef struct {
    logic [5:0] vec;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   n_run  = 0;
  int   n_fail = 0;

  panel_power_seq #(
    .TICKS_PER_MS (4),
    .T_VDD_MS     (2),
    .T_SIG_MS     (3),
    .T_BLOFF_MS   (1),
    .T_SIGOFF_MS  (2),
    .T_SWITCH_MS  (2)
  ) dut (
    .iCLK_PLL16  (iCLK_PLL16),
    .iRESET      (iRESET),
    .iENABLE     (iENABLE),
    .iPLL_LOCKED (iPLL_LOCKED),
    .iFRAME_RATE (iFRAME_RATE),
    .oVDD_EN     (oVDD_EN),
    .oSIG_EN     (oSIG_EN),
    .oBL_EN      (oBL_EN),
    .oSTB        (oSTB),
    .oCLK_SEL    (oCLK_SEL),
    .oBUSY       (oBUSY)
  );

  assign obs = {oVDD_EN, oSIG_EN, oBL_EN, oSTB, oCLK_SEL, oBUSY};

  initial iCLK_PLL16 = 1'b0;
  always #5 iCLK_PLL16 = ~iCLK_PLL16;

  // Expected output vector for a sequencer state and clock select.
  function automatic logic [5:0] ev(input int st, input logic c);
    logic vdd, sig, bl, busy;
    vdd = 1'b1; sig = 1'b0; bl = 1'b0; busy = 1'b1;
    case (st)
      E_OFF:        begin vdd = 1'b0; busy = 1'b0; end
      E_SIG:        sig = 1'b1;
      E_ON:         begin sig = 1'b1; bl = 1'b1; busy = 1'b0; end
      E_RBL, E_DBL: sig = 1'b1;
      default:      ;
    endcase
    return {vdd, sig, bl, sig, c, busy};
  endfunction

  task automatic push(input int n, input int st, input logic c, input string name);
    exp_t e;
    e.vec  = ev(st, c);
    e.name = name;
    repeat (n) exp_q.push_back(e);
  endtask

  task automatic test_reset();
    exp_t e;
    iRESET = 1'b0; iENABLE = 1'b0; iPLL_LOCKED = 1'b1; iFRAME_RATE = 2'd0;
    push(1, E_OFF, 1'b0, "reset_async");
    #3;
    e = exp_q.pop_front(); n_run++;
    if (obs !== e.vec) begin n_fail++; $display("FAIL %s: observed %b expected %b", e.name, obs, e.vec); end
    push(2, E_OFF, 1'b0, "reset_held");
    while (exp_q.size() > 0) begin
      @(posedge iCLK_PLL16); #1;
      e = exp_q.pop_front(); n_run++;
      if (obs !== e.vec) begin n_fail++; $display("FAIL %s: observed %b expected %b", e.name, obs, e.vec); end
    end
    iRESET = 1'b1;
    push(4, E_OFF, 1'b0, "idle_after_reset");
    while (exp_q.size() > 0) begin
      @(posedge iCLK_PLL16); #1;
      e = exp_q.pop_front(); n_run++;
      if (obs !== e.vec) begin n_fail++; $display("FAIL %s: observed %b expected %b", e.name, obs, e.vec); end
    end
  endtask

  task automatic test_power_up();
    exp_t e;
    iENABLE = 1'b1;
    push(2, E_OFF, 1'b0, "pu_off");
    push(8, E_PWR, 1'b0, "pu_pwr_up");
    push(12, E_SIG, 1'b0, "pu_sig_up");
    push(3, E_ON, 1'b0, "pu_on");
    while (exp_q.size() > 0) begin
      @(posedge iCLK_PLL16); #1;
      e = exp_q.pop_front(); n_run++;
      if (obs !== e.vec) begin n_fail++; $display("FAIL %s: observed %b expected %b", e.name, obs, e.vec); end
    end
  endtask

  // A one-cycle rate pulse and an unknown code (2 = 60 Hz) must not switch.
  task automatic test_rate_glitch();
    exp_t e;
    iFRAME_RATE = 2'd1;
    push(1, E_ON, 1'b0, "glitch_pulse");
    while (exp_q.size() > 0) begin
      @(posedge iCLK_PLL16); #1;
      e = exp_q.pop_front(); n_run++;
      if (obs !== e.vec) begin n_fail++; $display("FAIL %s: observed %b expected %b", e.name, obs, e.vec); end
    end
    iFRAME_RATE = 2'd0;
    push(6, E_ON, 1'b0, "glitch_rejected");
    while (exp_q.size() > 0) begin
      @(posedge iCLK_PLL16); #1;
      e = exp_q.pop_front(); n_run++;
      if (obs !== e.vec) begin n_fail++; $display("FAIL %s: observed %b expected %b", e.name, obs, e.vec); end
    end
    iFRAME_RATE = 2'd2;
    push(8, E_ON, 1'b0, "rate_code2_is_60hz");
    while (exp_q.size() > 0) begin
      @(posedge iCLK_PLL16); #1;
      e = exp_q.pop_front(); n_run++;
      if (obs !== e.vec) begin n_fail++; $display("FAIL %s: observed %b expected %b", e.name, obs, e.vec); end
    end
    iFRAME_RATE = 2'd0;
    push(4, E_ON, 1'b0, "rate_code_back_0");
    while (exp_q.size() > 0) begin
      @(posedge iCLK_PLL16); #1;
      e = exp_q.pop_front(); n_run++;
      if (obs !== e.vec) begin n_fail++; $display("FAIL %s: observed %b expected %b", e.name, obs, e.vec); end
    end
  endtask

  // 0->1 request, then back to 0 during RATE_SW: the select stays 1 through
  // SIG_UP, ON lasts one cycle, and a second switch restores 0.
  task automatic test_rate_toggle();
    exp_t e;
    iFRAME_RATE = 2'd1;
    push(3, E_ON, 1'b0, "tg_on");
    push(4, E_RBL, 1'b0, "tg_rate_bl");
    push(2, E_RSW, 1'b1, "tg_rate_sw");
    while (exp_q.size() > 0) begin
      @(posedge iCLK_PLL16); #1;
      e = exp_q.pop_front(); n_run++;
      if (obs !== e.vec) begin n_fail++; $display("FAIL %s: observed %b expected %b", e.name, obs, e.vec); end
    end
    iFRAME_RATE = 2'd0;
    push(6, E_RSW, 1'b1, "tg_rate_sw_hold");
    push(12, E_SIG, 1'b1, "tg_sig_up_sel1");
    push(1, E_ON, 1'b1, "tg_on_once");
    push(4, E_RBL, 1'b1, "tg2_rate_bl");
    push(8, E_RSW, 1'b0, "tg2_rate_sw");
    push(12, E_SIG, 1'b0, "tg2_sig_up");
    push(2, E_ON, 1'b0, "tg2_on");
    while (exp_q.size() > 0) begin
      @(posedge iCLK_PLL16); #1;
      e = exp_q.pop_front(); n_run++;
      if (obs !== e.vec) begin n_fail++; $display("FAIL %s: observed %b expected %b", e.name, obs, e.vec); end
    end
  endtask

  task automatic test_rate_switch();
    exp_t e;
    iFRAME_RATE = 2'd1;
    push(3, E_ON, 1'b0, "rs_on");
    push(4, E_RBL, 1'b0, "rs_rate_bl");
    push(8, E_RSW, 1'b1, "rs_rate_sw");
    push(12, E_SIG, 1'b1, "rs_sig_up");
    push(2, E_ON, 1'b1, "rs_on_sel1");
    while (exp_q.size() > 0) begin
      @(posedge iCLK_PLL16); #1;
      e = exp_q.pop_front(); n_run++;
      if (obs !== e.vec) begin n_fail++; $display("FAIL %s: observed %b expected %b", e.name, obs, e.vec); end
    end
  endtask

  task automatic test_power_down();
    exp_t e;
    iENABLE = 1'b0;
    push(2, E_ON, 1'b1, "pd_on");
    push(4, E_DBL, 1'b1, "pd_dn_bl");
    push(8, E_DSIG, 1'b1, "pd_dn_sig");
    push(3, E_OFF, 1'b1, "pd_off");
    while (exp_q.size() > 0) begin
      @(posedge iCLK_PLL16); #1;
      e = exp_q.pop_front(); n_run++;
      if (obs !== e.vec) begin n_fail++; $display("FAIL %s: observed %b expected %b", e.name, obs, e.vec); end
    end
  endtask

  task automatic test_off_tracking();
    exp_t e;
    iFRAME_RATE = 2'd0;
    push(3, E_OFF, 1'b1, "off_sel_old");
    push(3, E_OFF, 1'b0, "off_sel_tracks");
    while (exp_q.size() > 0) begin
      @(posedge iCLK_PLL16); #1;
      e = exp_q.pop_front(); n_run++;
      if (obs !== e.vec) begin n_fail++; $display("FAIL %s: observed %b expected %b", e.name, obs, e.vec); end
    end
  endtask

  task automatic test_abort();
    exp_t e;
    iENABLE = 1'b1;
    push(2, E_OFF, 1'b0, "ab_off");
    push(2, E_PWR, 1'b0, "ab_pwr_up");
    while (exp_q.size() > 0) begin
      @(posedge iCLK_PLL16); #1;
      e = exp_q.pop_front(); n_run++;
      if (obs !== e.vec) begin n_fail++; $display("FAIL %s: observed %b expected %b", e.name, obs, e.vec); end
    end
    iENABLE = 1'b0;
    push(2, E_PWR, 1'b0, "ab_pwr_sync");
    push(8, E_DSIG, 1'b0, "ab_dn_sig");
    push(2, E_OFF, 1'b0, "ab_off_end");
    while (exp_q.size() > 0) begin
      @(posedge iCLK_PLL16); #1;
      e = exp_q.pop_front(); n_run++;
      if (obs !== e.vec) begin n_fail++; $display("FAIL %s: observed %b expected %b", e.name, obs, e.vec); end
    end
  endtask

  // Lock loss in ON; lock returns during DN_BL and is ignored until OFF,
  // after which a fresh power-up starts on the next edge.
  task automatic test_lock_loss();
    exp_t e;
    iENABLE = 1'b1;
    push(2, E_OFF, 1'b0, "ll_off");
    push(8, E_PWR, 1'b0, "ll_pwr_up");
    push(12, E_SIG, 1'b0, "ll_sig_up");
    push(2, E_ON, 1'b0, "ll_on");
    while (exp_q.size() > 0) begin
      @(posedge iCLK_PLL16); #1;
      e = exp_q.pop_front(); n_run++;
      if (obs !== e.vec) begin n_fail++; $display("FAIL %s: observed %b expected %b", e.name, obs, e.vec); end
    end
    iPLL_LOCKED = 1'b0;
    push(2, E_ON, 1'b0, "ll_on_sync");
    push(4, E_DBL, 1'b0, "ll_dn_bl");
    while (exp_q.size() > 0) begin
      @(posedge iCLK_PLL16); #1;
      e = exp_q.pop_front(); n_run++;
      if (obs !== e.vec) begin n_fail++; $display("FAIL %s: observed %b expected %b", e.name, obs, e.vec); end
    end
    iPLL_LOCKED = 1'b1;
    push(8, E_DSIG, 1'b0, "ll_dn_sig_ignores_go");
    push(1, E_OFF, 1'b0, "ll_off_once");
    push(8, E_PWR, 1'b0, "ll_repower");
    push(12, E_SIG, 1'b0, "ll_resig");
    push(2, E_ON, 1'b0, "ll_reon");
    while (exp_q.size() > 0) begin
      @(posedge iCLK_PLL16); #1;
      e = exp_q.pop_front(); n_run++;
      if (obs !== e.vec) begin n_fail++; $display("FAIL %s: observed %b expected %b", e.name, obs, e.vec); end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    for (int pass = 0; pass < 2; pass++) begin
      iRESET = 1'b0;
      push(1, E_OFF, 1'b0, (pass == 0) ? "rst_from_on" : "rst_mid_sig_up");
      #2;
      e = exp_q.pop_front(); n_run++;
      if (obs !== e.vec) begin n_fail++; $display("FAIL %s: observed %b expected %b", e.name, obs, e.vec); end
      push(2, E_OFF, 1'b0, "rst_hold");
      while (exp_q.size() > 0) begin
        @(posedge iCLK_PLL16); #1;
        e = exp_q.pop_front(); n_run++;
        if (obs !== e.vec) begin n_fail++; $display("FAIL %s: observed %b expected %b", e.name, obs, e.vec); end
      end
      iRESET = 1'b1;
      push(2, E_OFF, 1'b0, "rst_rel_off");
      push(8, E_PWR, 1'b0, "rst_rel_pwr_up");
      if (pass == 0) begin
        push(3, E_SIG, 1'b0, "rst_rel_sig_up");
      end else begin
        push(12, E_SIG, 1'b0, "rst_replay_sig_up");
        push(2, E_ON, 1'b0, "rst_replay_on");
      end
      while (exp_q.size() > 0) begin
        @(posedge iCLK_PLL16); #1;
        e = exp_q.pop_front(); n_run++;
        if (obs !== e.vec) begin n_fail++; $display("FAIL %s: observed %b expected %b", e.name, obs, e.vec); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_rate_glitch();
    test_rate_toggle();
    test_rate_switch();
    test_power_down();
    test_off_tracking();
    test_abort();
    test_lock_loss();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
